word_byte_unpacker: RTL and testbench
=====================================

# word_byte_unpacker

Receiving-side counterpart of the 16-bit word writer path: accepts 16-bit words over a valid/ready handshake and emits them as two consecutive bytes over a byte-wide valid/ready handshake. It sits between any 16-bit word producer and byte-oriented consumers (byte FIFOs, UART TX, byte buses), holding one word at a time and sustaining one byte per cycle with no bubbles under continuous traffic. A wrapping completed-word counter is provided for status and debug.

## Interface
- MSB_FIRST, default 0: 0 emits in_data[7:0] then in_data[15:8]; 1 emits in_data[15:8] then in_data[7:0].
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- in_data  input  16  word to unpack; sampled only on an input transfer.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block can accept a word this cycle.
- out_data  output  8  current byte.
- out_valid  output  1  out_data holds a valid byte.
- out_ready  input  1  consumer accepts the byte this cycle.
- out_last  output  1  current byte is the second byte of its word.
- busy  output  1  a word is held (state != IDLE).
- word_count  output  8  number of words fully emitted, mod 256.

## Operation
- Input transfer: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready at a rising edge.
- Holding register hold[15:0] captures in_data on every input transfer; otherwise unchanged.
- States: IDLE, FIRST, SECOND.
  - IDLE: out_valid=0, in_ready=1. Input transfer -> FIRST.
  - FIRST: out_valid=1, out_last=0, in_ready=0, out_data = first byte of hold. Output transfer -> SECOND; else stay.
  - SECOND: out_valid=1, out_last=1, out_data = second byte of hold, in_ready = out_ready (combinational). Output transfer with in_valid=1 -> capture new word, go to FIRST. Output transfer with in_valid=0 -> IDLE. No output transfer -> stay, no capture.
- First/second byte selection fixed by MSB_FIRST per Interface.
- out_data in IDLE equals first byte of hold (don't-care to consumers, but deterministic).
- word_count increments by 1 on every output transfer in SECOND; 8-bit, wraps 255 -> 0.
- busy = (state != IDLE).
- in_data ignored whenever no input transfer occurs; changes to in_data while held do not affect out_data.
- out_data, out_last stable while out_valid=1 and out_ready=0 (valid/ready rule: no retraction, no change until accepted).

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, hold=16'h0000, word_count=0. Outputs: out_valid=0, out_last=0, out_data=8'h00, busy=0, in_ready=1. No capture while rst_n=0 regardless of in_valid. Deassertion synchronous-safe by integrating logic; first possible capture at first rising edge with rst_n=1.
- Reset mid-word: held word discarded, no partial byte emitted after release, word_count=0.
- Latency: word accepted at edge N -> first byte valid from edge N (visible in cycle N+1); second byte the cycle after first byte accepted.
- Throughput: continuous in_valid=1, out_ready=1 -> one byte every cycle, one word every 2 cycles, in_ready high every other cycle (in SECOND).
- Only combinational path input->output: out_ready -> in_ready in SECOND. out_valid, out_data, out_last, busy, word_count are register-derived.
- Back-pressure: out_ready=0 freezes state, hold, outputs; in_ready=0 in FIRST/SECOND.

## Test plan
- Reset: assert rst_n=0 mid-cycle with in_valid=1, in_data=16'hBEEF -> immediately out_valid=0, busy=0, word_count=0, in_ready=1; after release no byte appears without a new transfer.
- Single word, MSB_FIRST=0: in_data=16'hA55A, out_ready=1 -> bytes 8'h5A (out_last=0) then 8'hA5 (out_last=1), word_count=1, back to IDLE (busy=0).
- Back-to-back, MSB_FIRST=1: words 16'h1234, 16'h5678, 16'h9ABC with in_valid held, out_ready=1 -> bytes 12,34,56,78,9A,BC on 6 consecutive cycles, no gaps, word_count=3.
- Back-pressure: word 16'hCAFE, out_ready=0 for 5 cycles in FIRST then pulsed -> out_data stays 8'hFE, in_ready=0 throughout; in SECOND with out_ready=0 in_ready=0 and in_data changes ignored.
- Wrap: stream 257 words -> word_count reads 8'h00 after 256th, 8'h01 after 257th.
- Reset mid-word: reset asserted while in SECOND of 16'h00FF -> out_valid drops asynchronously, second byte never emitted, word_count=0.

Source files
------------

// File: rtl/word_byte_unpacker.sv
// word_byte_unpacker: accepts 16-bit words over valid/ready and emits them as
// two consecutive bytes over a byte-wide valid/ready handshake, one word held
// at a time, with a wrapping count of fully emitted words.
module word_byte_unpacker #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [7:0]  out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        out_last_o,
  output logic        busy_o,
  output logic [7:0]  word_count_o
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 8;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FIRST  = 2'd1;
  localparam logic [1:0] SECOND = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [BYTE_W-1:0] lo_byte, hi_byte, first_byte, second_byte;

  assign lo_byte     = hold_q[BYTE_W-1:0];
  assign hi_byte     = hold_q[WORD_W-1:BYTE_W];
  assign first_byte  = MSB_FIRST ? hi_byte : lo_byte;
  assign second_byte = MSB_FIRST ? lo_byte : hi_byte;

  // State, holding word and completed-word counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      count_q <= count_d;
    end
  end

  // Next-state, capture and counter update; in_ready follows out_ready in SECOND
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    count_d    = count_q;
    in_ready_o = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          hold_d  = in_data_i;
          state_d = FIRST;
        end
      end
      FIRST: begin
        if (out_ready_i) begin
          state_d = SECOND;
        end
      end
      SECOND: begin
        in_ready_o = out_ready_i;
        if (out_ready_i) begin
          count_d = count_q + CNT_W'(1);
          if (in_valid_i) begin
            hold_d  = in_data_i;
            state_d = FIRST;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Byte-side outputs decoded from registered state and held word
  always_comb begin
    out_valid_o  = (state_q == FIRST) || (state_q == SECOND);
    out_last_o   = (state_q == SECOND);
    busy_o       = (state_q != IDLE);
    out_data_o   = (state_q == SECOND) ? second_byte : first_byte;
    word_count_o = count_q;
  end

endmodule

// File: tb/tb_word_byte_unpacker.sv
// Bench for word_byte_unpacker: both byte orders run in lockstep on shared
// stimulus; a queue of pending bytes is the reference for every output.
module tb_word_byte_unpacker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        out_ready;

  logic       in_ready0, out_valid0, out_last0, busy0;
  logic [7:0] out_data0, wc0;
  logic       in_ready1, out_valid1, out_last1, busy1;
  logic [7:0] out_data1, wc1;

  word_byte_unpacker #(.MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready0),
    .out_data_o(out_data0), .out_valid_o(out_valid0), .out_ready_i(out_ready),
    .out_last_o(out_last0), .busy_o(busy0), .word_count_o(wc0)
  );

  word_byte_unpacker #(.MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready1),
    .out_data_o(out_data1), .out_valid_o(out_valid1), .out_ready_i(out_ready),
    .out_last_o(out_last1), .busy_o(busy1), .word_count_o(wc1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] w;
    bit          last;
  } ent_t;

  ent_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          wc_model = 0;
  logic [15:0] last_word = 16'h0000;
  int          mon_n;
  ent_t        mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every output against the pending-byte queue each cycle
  always @(negedge clk) begin
    if (rst_n) begin
      mon_n = q.size();
      check("out_valid0", 32'(out_valid0), 32'(mon_n != 0));
      check("out_valid1", 32'(out_valid1), 32'(mon_n != 0));
      check("busy0", 32'(busy0), 32'(mon_n != 0));
      check("busy1", 32'(busy1), 32'(mon_n != 0));
      check("in_ready0", 32'(in_ready0), 32'((mon_n == 0) || (mon_n == 1 && out_ready)));
      check("in_ready1", 32'(in_ready1), 32'((mon_n == 0) || (mon_n == 1 && out_ready)));
      check("word_count0", 32'(wc0), 32'(wc_model & 255));
      check("word_count1", 32'(wc1), 32'(wc_model & 255));
      if (mon_n != 0) begin
        mon_e = q[0];
        check("out_data0", 32'(out_data0), 32'(mon_e.last ? mon_e.w[15:8] : mon_e.w[7:0]));
        check("out_data1", 32'(out_data1), 32'(mon_e.last ? mon_e.w[7:0] : mon_e.w[15:8]));
        check("out_last0", 32'(out_last0), 32'(mon_e.last));
        check("out_last1", 32'(out_last1), 32'(mon_e.last));
      end else begin
        check("idle_data0", 32'(out_data0), 32'(last_word[7:0]));
        check("idle_data1", 32'(out_data1), 32'(last_word[15:8]));
      end
      if (out_valid0 && out_ready) begin
        if (mon_n == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got %0h expected none at %0t", out_data0, $time);
        end else begin
          if (q[0].last) wc_model++;
          void'(q.pop_front());
        end
      end
    end
  end

  // Scoreboard feed: an accepted word queues its two bytes
  always @(negedge clk) begin
    #1;
    if (rst_n && in_valid && in_ready0) begin
      q.push_back('{w: in_data, last: 1'b0});
      q.push_back('{w: in_data, last: 1'b1});
      last_word = in_data;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a word and hold it until accepted; leaves in_valid high
  task automatic send(input logic [15:0] w);
    logic got;
    in_valid = 1'b1;
    in_data  = w;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      got = in_ready0;
      @(posedge clk);
      #1;
      if (got) return;
    end
    total++;
    bad++;
    $display("FAIL send_timeout: got no in_ready expected accept of %0h", w);
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid0", 32'(out_valid0), 32'd0);
    check("rst_out_valid1", 32'(out_valid1), 32'd0);
    check("rst_busy0", 32'(busy0), 32'd0);
    check("rst_wc0", 32'(wc0), 32'd0);
    check("rst_in_ready0", 32'(in_ready0), 32'd1);
    check("rst_in_ready1", 32'(in_ready1), 32'd1);
    check("rst_last0", 32'(out_last0), 32'd0);
    check("rst_data0", 32'(out_data0), 32'h00);
    check("rst_data1", 32'(out_data1), 32'h00);
    q.delete();
    wc_model  = 0;
    last_word = 16'h0000;
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b0;
    release_rst();
    cyc(2);

    // Reset asserted mid-cycle while a word is offered
    #2;
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    async_reset();
    cyc(1);
    in_valid = 1'b0;
    release_rst();
    out_ready = 1'b1;
    cyc(3);

    // Single word, both byte orders
    send(16'hA55A);
    in_valid = 1'b0;
    cyc(3);
    check("single_wc", 32'(wc0), 32'd1);
    check("single_busy", 32'(busy0), 32'd0);

    // Back-to-back words with continuous ready
    send(16'h1234);
    send(16'h5678);
    send(16'h9ABC);
    in_valid = 1'b0;
    cyc(3);
    check("b2b_wc", 32'(wc1), 32'd4);

    // Back-pressure in FIRST then in SECOND
    out_ready = 1'b0;
    send(16'hCAFE);
    in_valid = 1'b0;
    repeat (5) begin
      in_data = 16'($urandom);
      #1;
      check("bp_first_byte0", 32'(out_data0), 32'hFE);
      check("bp_first_byte1", 32'(out_data1), 32'hCA);
      check("bp_first_ready", 32'(in_ready0), 32'd0);
      cyc(1);
    end
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (3) begin
      in_data = 16'($urandom);
      #1;
      check("bp_second_byte0", 32'(out_data0), 32'hCA);
      check("bp_second_ready", 32'(in_ready0), 32'd0);
      cyc(1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc(3);
    check("bp_wc", 32'(wc0), 32'd5);

    // Reset while the second byte of 16'h00FF is pending
    out_ready = 1'b0;
    send(16'h00FF);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    #2;
    async_reset();
    release_rst();
    out_ready = 1'b1;
    cyc(4);
    check("midrst_wc", 32'(wc0), 32'd0);
    check("midrst_busy", 32'(busy0), 32'd0);

    // Counter wrap over 257 words
    for (int i = 0; i < 257; i++) send(16'($urandom));
    in_valid = 1'b0;
    cyc(3);
    check("wrap_wc0", 32'(wc0), 32'd1);
    check("wrap_wc1", 32'(wc1), 32'd1);

    // Randomised traffic with random back-pressure
    for (int i = 0; i < 600; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc(1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc(4);
    check("drain_busy0", 32'(busy0), 32'd0);
    check("drain_busy1", 32'(busy1), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
